// File: rtl/input_port_unit.sv
// Mesh router input port: flit FIFO, XY route computation from the head flit,
// and wormhole request/lock presentation to the output arbiter.
module input_port_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int COORD_W    = 2,
   parameter int DEPTH      = 4,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH+1:0] flit_i,
   output logic                  ready_o,
   output logic [5:0]            dir_o,
   output logic                  is_body_o,
   input  logic                  grant_i,
   output logic [DATA_WIDTH+1:0] flit_o,
   output logic                  flit_valid_o,
   output logic                  err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = DATA_WIDTH + 2;
   localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
   localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

   typedef enum logic [1:0] {IDLE, ROUTED, BODY} state_t;

   logic [FW-1:0]      mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]        count_q, count_d;
   state_t             state_q, state_d;
   logic [5:0]         dir_q, dir_d;
   logic               push, pop, empty, fwd, drop;
   logic [1:0]         head_type;
   logic [COORD_W-1:0] dest_x, dest_y;
   logic [4:0]         route;

   assign flit_o    = mem_q[rd_ptr_q];
   assign head_type = flit_o[FW-1:DATA_WIDTH];
   assign dest_x    = flit_o[COORD_W-1:0];
   assign dest_y    = flit_o[2*COORD_W-1:COORD_W];

   always_comb begin
      route = '0;
      if (dest_x > CX)      route[3] = 1'b1;
      else if (dest_x < CX) route[2] = 1'b1;
      else if (dest_y > CY) route[4] = 1'b1;
      else if (dest_y < CY) route[1] = 1'b1;
      else                  route[0] = 1'b1;
   end

   always_comb begin
      empty   = (count_q == '0);
      ready_o = (count_q != (AW+1)'(DEPTH));
      push    = valid_i & ready_o;
      fwd     = grant_i & dir_q[5] & ~empty & (state_q != IDLE);
      // head types (01, 11) have bit 0 set; anything else at the front in IDLE is an orphan
      drop    = (state_q == IDLE) & ~empty & ~head_type[0];
      pop     = fwd | drop;

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

      state_d = state_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (!empty && head_type[0]) begin
               dir_d   = {1'b1, route};
               state_d = ROUTED;
            end
         end
         ROUTED: begin
            if (fwd) begin
               if (head_type == 2'b11) begin
                  state_d = IDLE;
                  dir_d   = '0;
               end else begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            if (fwd && head_type == 2'b10) begin
               state_d = IDLE;
               dir_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            dir_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         dir_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         dir_q    <= dir_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= flit_i;
   end

   assign dir_o        = dir_q;
   assign is_body_o    = (state_q == BODY);
   assign flit_valid_o = fwd;
   assign err_o        = drop;

endmodule

// File: tb/tb_input_port_unit.sv
// Bench for input_port_unit at router (1,1): directed vector table, reset and
// full-FIFO sequences, then random traffic against a queue-based reference.
module tb_input_port_unit;

   localparam int DW = 32;
   localparam int FW = DW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic [FW-1:0] flit_i;
   logic          ready_o;
   logic [5:0]    dir_o;
   logic          is_body_o;
   logic          grant_i;
   logic [FW-1:0] flit_o;
   logic          flit_valid_o;
   logic          err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   input_port_unit #(
      .DATA_WIDTH(DW), .COORD_W(2), .DEPTH(4), .CUR_X(1), .CUR_Y(1)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flit_i(flit_i),
      .ready_o(ready_o), .dir_o(dir_o), .is_body_o(is_body_o),
      .grant_i(grant_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
      .err_o(err_o)
   );

   typedef struct {
      logic          v;
      logic [FW-1:0] f;
      logic          g;
      logic          rdy;
      logic [5:0]    dir;
      logic          body;
      logic          fv;
      logic          err;
      logic [FW-1:0] fo;
   } vec_t;

   vec_t tbl [15];

   localparam logic [FW-1:0] H1 = {2'b11, 32'hABCD_0007}; // to (3,1): east
   localparam logic [FW-1:0] PH = {2'b01, 32'h1111_0001}; // to (1,0): south
   localparam logic [FW-1:0] PB = {2'b00, 32'h2222_0000};
   localparam logic [FW-1:0] PT = {2'b10, 32'h3333_0000};
   localparam logic [FW-1:0] OR = {2'b00, 32'hDEAD_0000};
   localparam logic [FW-1:0] H2 = {2'b11, 32'h4444_0005}; // to (1,1): local
   localparam logic [FW-1:0] Z  = '0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] route_of(input logic [FW-1:0] f);
      int dx, dy;
      dx = int'(f[1:0]);
      dy = int'(f[3:2]);
      if (dx > 1) return 5'b01000;
      if (dx < 1) return 5'b00100;
      if (dy > 1) return 5'b10000;
      if (dy < 1) return 5'b00010;
      return 5'b00001;
   endfunction

   logic [FW-1:0] got_q [$];
   logic [FW-1:0] exp_full [4];
   logic [FW-1:0] mq [$];
   logic [5:0]    m_dir, n_dir;
   bit            m_body, n_body;
   bit            e_rdy, e_fv, e_err;
   logic [FW-1:0] e_fo, rf;
   logic [1:0]    ty;

   initial begin
      tbl[0]  = '{1'b1, H1, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[1]  = '{1'b0, Z,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[2]  = '{1'b0, Z,  1'b1, 1'b1, 6'b101000, 1'b0, 1'b1, 1'b0, H1};
      tbl[3]  = '{1'b0, Z,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[4]  = '{1'b1, PH, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[5]  = '{1'b1, PB, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[6]  = '{1'b1, PT, 1'b1, 1'b1, 6'b100010, 1'b0, 1'b1, 1'b0, PH};
      tbl[7]  = '{1'b0, Z,  1'b1, 1'b1, 6'b100010, 1'b1, 1'b1, 1'b0, PB};
      tbl[8]  = '{1'b0, Z,  1'b1, 1'b1, 6'b100010, 1'b1, 1'b1, 1'b0, PT};
      tbl[9]  = '{1'b0, Z,  1'b1, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[10] = '{1'b1, OR, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[11] = '{1'b1, H2, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, Z};
      tbl[12] = '{1'b0, Z,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};
      tbl[13] = '{1'b0, Z,  1'b1, 1'b1, 6'b100001, 1'b0, 1'b1, 1'b0, H2};
      tbl[14] = '{1'b0, Z,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, Z};

      // reset held with valid_i high: nothing may be captured
      rst = 1'b0; valid_i = 1'b1; flit_i = PH; grant_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", 64'(ready_o), 64'(1));
         chk("rst_dir", 64'(dir_o), 64'(0));
         chk("rst_body", 64'(is_body_o), 64'(0));
         chk("rst_fv_err", 64'({flit_valid_o, err_o}), 64'(0));
      end
      rst = 1'b1; valid_i = 1'b0; flit_i = Z;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_empty", 64'({dir_o, err_o}), 64'(0));
      end

      for (int i = 0; i < 15; i++) begin
         valid_i = tbl[i].v; flit_i = tbl[i].f; grant_i = tbl[i].g;
         #2;
         chk($sformatf("tbl%0d_ready", i), 64'(ready_o), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d_dir", i), 64'(dir_o), 64'(tbl[i].dir));
         chk($sformatf("tbl%0d_body", i), 64'(is_body_o), 64'(tbl[i].body));
         chk($sformatf("tbl%0d_fv", i), 64'(flit_valid_o), 64'(tbl[i].fv));
         chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].err));
         if (tbl[i].fv) chk($sformatf("tbl%0d_flit", i), 64'(flit_o), 64'(tbl[i].fo));
         step();
      end
      valid_i = 1'b0; grant_i = 1'b0;

      // full FIFO: fifth flit offered while full must vanish
      exp_full[0] = {2'b01, 32'hF000_0005};
      exp_full[1] = {2'b00, 32'hF111_0000};
      exp_full[2] = {2'b00, 32'hF222_0000};
      exp_full[3] = {2'b10, 32'hF333_0000};
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         flit_i  = (i < 4) ? exp_full[i] : {2'b00, 32'hBAD0_0000};
         #2;
         chk($sformatf("full_ready%0d", i), 64'(ready_o), 64'(i < 4));
         step();
      end
      valid_i = 1'b0; grant_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #2;
         if (flit_valid_o) got_q.push_back(flit_o);
         step();
      end
      grant_i = 1'b0;
      chk("full_count", 64'(got_q.size()), 64'(4));
      for (int i = 0; i < 4; i++)
         if (i < got_q.size()) chk($sformatf("full_flit%0d", i), 64'(got_q[i]), 64'(exp_full[i]));

      // reset in the middle of a packet
      valid_i = 1'b1; flit_i = PH; step();
      flit_i = PB; step();
      grant_i = 1'b1; #2;
      chk("mid_head_fv", 64'(flit_valid_o), 64'(1));
      chk("mid_head_flit", 64'(flit_o), 64'(PH));
      step();
      valid_i = 1'b0; grant_i = 1'b0; #2;
      chk("mid_in_body", 64'(is_body_o), 64'(1));
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_dir", 64'(dir_o), 64'(0));
      chk("mid_rst_body", 64'(is_body_o), 64'(0));
      chk("mid_rst_ready", 64'(ready_o), 64'(1));
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_post_empty", 64'({dir_o, err_o}), 64'(0));
      end
      valid_i = 1'b1; flit_i = H1; step();
      valid_i = 1'b0; step();
      grant_i = 1'b1; #2;
      chk("mid_new_dir", 64'(dir_o), 64'(6'b101000));
      chk("mid_new_fv", 64'({flit_valid_o, flit_o}), 64'({1'b1, H1}));
      step();
      grant_i = 1'b0;
      step();

      // random traffic against the queue reference
      m_dir = '0; m_body = 0;
      for (int c = 0; c < 600; c++) begin
         valid_i = ($urandom_range(0, 1) == 1);
         rf = {$urandom_range(0, 3) == 0 ? 2'b00 : 2'($urandom_range(0, 3)), $urandom()};
         flit_i = rf;
         grant_i = ($urandom_range(0, 2) != 0);
         #2;
         e_rdy = (mq.size() < 4); e_fv = 0; e_err = 0; e_fo = '0;
         n_dir = m_dir; n_body = m_body;
         if (m_dir == 0) begin
            if (mq.size() > 0) begin
               if (mq[0][32]) n_dir = {1'b1, route_of(mq[0])};
               else begin e_err = 1; void'(mq.pop_front()); end
            end
         end else if (grant_i && mq.size() > 0) begin
            e_fv = 1; e_fo = mq.pop_front(); ty = e_fo[33:32];
            if ((!m_body && ty == 2'b11) || (m_body && ty == 2'b10)) begin
               n_dir = '0; n_body = 0;
            end else n_body = 1;
         end
         chk("rnd_ready", 64'(ready_o), 64'(e_rdy));
         chk("rnd_dir", 64'(dir_o), 64'(m_dir));
         chk("rnd_body", 64'(is_body_o), 64'(m_body));
         chk("rnd_fv_err", 64'({flit_valid_o, err_o}), 64'({e_fv, e_err}));
         if (e_fv) chk("rnd_flit", 64'(flit_o), 64'(e_fo));
         if (valid_i && e_rdy) mq.push_back(rf);
         step();
         m_dir = n_dir; m_body = n_body;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/input_port_unit.md
# input_port_unit

Per-input-port front end of the 5-port mesh router: buffers incoming flits in a small FIFO, computes the XY route of each packet from its head flit, and presents a registered one-hot output request plus a wormhole body-lock flag to the output arbiter. One instance per input direction (north, east, west, south, local). It dequeues and forwards flits only when the arbiter grants this port.

## Interface
- DATA_WIDTH, 32, flit payload width.
- COORD_W, 2, width of each X/Y mesh coordinate.
- DEPTH, 4, FIFO depth in flits; power of two, ≥2.
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream flit valid.
- flit_i  in  DATA_WIDTH+2  flit; [DATA_WIDTH+1:DATA_WIDTH] = type (01 head, 00 body, 10 tail, 11 head+tail); head dest X = [COORD_W-1:0], dest Y = [2*COORD_W-1:COORD_W].
- ready_o  out  1  FIFO can accept a flit this cycle.
- dir_o  out  6  request to arbiter; bit5 = request active, [4:0] one-hot north/east/west/south/local.
- is_body_o  out  1  packet head already forwarded; arbiter must keep this port's grant.
- grant_i  in  1  arbiter grant for this port.
- flit_o  out  DATA_WIDTH+2  FIFO head flit.
- flit_valid_o  out  1  flit_o transferred this cycle.
- err_o  out  1  one-cycle pulse: orphan body/tail flit dropped.

## Operation
- FIFO: push when valid_i & ready_o; ready_o = (count != DEPTH). valid_i while full is ignored, flit lost (upstream must honour ready_o). Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- XY route from head flit: dest X > CUR_X → east (bit3); dest X < CUR_X → west (bit2); X equal and dest Y > CUR_Y → north (bit4); dest Y < CUR_Y → south (bit1); both equal → local (bit0). Coordinates compared unsigned.
- State machine:
  - IDLE: dir_o = 0, is_body_o = 0. If FIFO non-empty and head type is head/head+tail: register route into dir_o (bit5 = 1), go ROUTED. If head type is body/tail: pop it, pulse err_o, stay IDLE.
  - ROUTED: dir_o held, is_body_o = 0. On grant_i: pop, flit_valid_o = 1; type head+tail → IDLE (dir_o = 0 next cycle), else → BODY.
  - BODY: dir_o held, is_body_o = 1. On grant_i with FIFO non-empty: pop, flit_valid_o = 1; tail → IDLE; body → stay. A head flit at FIFO front in BODY is treated as body (no re-route).
- flit_valid_o = grant_i & dir_o[5] & FIFO non-empty & state ∈ {ROUTED, BODY}; grant_i in any other case is ignored, nothing popped.
- flit_o = FIFO head combinationally; value don't-care when flit_valid_o = 0.

## Timing
- Reset (rst = 0, asynchronous): FIFO emptied, state IDLE; ready_o = 1, dir_o = 0, is_body_o = 0, flit_valid_o = 0, err_o = 0. Reset mid-packet discards all buffered flits and the route.
- Head pushed at edge N → in FIFO cycle N+1 → dir_o valid from cycle N+2 (route register). Earliest forward: grant_i in cycle N+2, flit_valid_o same cycle.
- One flit forwarded per granted cycle; back-to-back body flits with continuous grant stream at full rate.
- After tail pop at edge M, dir_o = 0 in cycle M+1; next head routed at M+1, dir_o valid M+2 (one bubble cycle between packets).
- err_o asserted exactly one cycle per dropped flit.
- ready_o reflects count after the previous edge (no same-cycle pop bypass).

## Test plan
- Reset: hold rst = 0 with valid_i = 1 → ready_o = 1, dir_o = 6'b000000, is_body_o = 0, no flit stored after release.
- CUR=(1,1): single head+tail flit to (3,1) pushed at edge 0 → dir_o = 6'b101000 from cycle 2; grant in cycle 2 → flit_valid_o = 1, flit_o equals pushed flit, dir_o = 0 in cycle 3.
- CUR=(1,1): 3-flit packet to (1,0), grant held high → dir_o = 6'b100010; head forwarded cycle 2, is_body_o = 1 cycles 3–4, tail forwarded cycle 4, dir_o = 0 cycle 5.
- Full: push 5 flits, grant_i = 0 → ready_o = 0 after 4th push; 5th flit absent from later output stream.
- Orphan body flit pushed in IDLE → popped, err_o = 1 for one cycle, dir_o stays 0; following head routes normally.
- Assert rst = 0 mid-packet (after head forwarded) → dir_o = 0, is_body_o = 0, FIFO empty immediately; new head after release routes normally.
